// File: rtl/tmds_rx_word_aligner.sv
// TMDS receive gearbox: packs 5-bit deserialiser chunks into 10-bit symbols and hunts for symbol alignment.
// Optional lossCount output is enabled by defining TMDS_RX_LOSS_COUNT_EN.
module tmds_rx_word_aligner #(
  parameter int LOCK_RUN     = 8,
  parameter int SEARCH_DWELL = 4096,
  parameter int LOSS_TIMEOUT = 1048576
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serialValid,
  input  logic [4:0] serialData,
  input  logic       forceRelock,
  output logic [9:0] word,
  output logic       wordValid,
  output logic       isControl,
  output logic       locked,
  output logic [3:0] offset
`ifdef TMDS_RX_LOSS_COUNT_EN
  ,
  output logic [7:0] lossCount
`endif
);

  localparam int RW = 8;
  localparam int DW = $clog2(SEARCH_DWELL + 1);
  localparam int GW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_LIM   = RW'(LOCK_RUN);
  localparam logic [DW-1:0] DWELL_LIM = DW'(SEARCH_DWELL);
  localparam logic [GW-1:0] GAP_LIM   = GW'(LOSS_TIMEOUT);

  typedef enum logic {SEARCH, LOCKED} state_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [9:0] select_word(input logic [19:0] h, input logic [3:0] o);
    logic [9:0] w;
    case (o)
      4'd0:    w = h[9:0];
      4'd1:    w = h[10:1];
      4'd2:    w = h[11:2];
      4'd3:    w = h[12:3];
      4'd4:    w = h[13:4];
      4'd5:    w = h[14:5];
      4'd6:    w = h[15:6];
      4'd7:    w = h[16:7];
      4'd8:    w = h[17:8];
      4'd9:    w = h[18:9];
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o >= 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  function automatic logic [RW-1:0] sat_inc_run(input logic [RW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DW-1:0] sat_inc_dwell(input logic [DW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [GW-1:0] sat_inc_gap(input logic [GW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [19:0]   history;
  logic [19:0]   history_p0;
  logic          phase;
  logic [9:0]    word_p0;
  logic          ctl_p0;
  logic          vld_p0;
  logic [9:0]    word_p1;
  logic          ctl_p1;
  logic          vld_p1;

  state_t        state, state_n;
  logic [RW-1:0] run, run_n, run_inc;
  logic [DW-1:0] dwell, dwell_n, dwell_inc;
  logic [GW-1:0] gap, gap_n, gap_inc;
  logic [3:0]    offset_q, offset_n;

  // stage p0: shift in the new chunk and cut the candidate symbol at the current offset
  assign history_p0 = {serialData, history[19:5]};
  assign word_p0    = select_word(history_p0, offset_q);
  assign ctl_p0     = is_token(word_p0);
  assign vld_p0     = serialValid && phase;

  // stage p1: registered symbol, qualifier and control-token flag
  always_ff @(posedge clock) begin
    if (reset) begin
      history <= '0;
      phase   <= 1'b0;
      word_p1 <= '0;
      ctl_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (serialValid) begin
        history <= history_p0;
        phase   <= ~phase;
      end
      if (vld_p0) begin
        word_p1 <= word_p0;
        ctl_p1  <= ctl_p0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SEARCH;
      run      <= '0;
      dwell    <= '0;
      gap      <= '0;
      offset_q <= '0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      dwell    <= dwell_n;
      gap      <= gap_n;
      offset_q <= offset_n;
    end
  end

  // The alignment FSM steps once per emitted symbol, judging the symbol being registered this cycle.
  always_comb begin
    state_n   = state;
    run_n     = run;
    dwell_n   = dwell;
    gap_n     = gap;
    offset_n  = offset_q;
    run_inc   = ctl_p0 ? sat_inc_run(run) : '0;
    dwell_inc = sat_inc_dwell(dwell);
    gap_inc   = ctl_p0 ? '0 : sat_inc_gap(gap);
    if (forceRelock) begin
      state_n  = SEARCH;
      offset_n = next_offset(offset_q);
      run_n    = '0;
      dwell_n  = '0;
      gap_n    = '0;
    end else if (vld_p0) begin
      case (state)
        SEARCH: begin
          if (run_inc >= RUN_LIM) begin
            state_n = LOCKED;
            run_n   = '0;
            dwell_n = '0;
            gap_n   = '0;
          end else if (dwell_inc >= DWELL_LIM) begin
            offset_n = next_offset(offset_q);
            run_n    = '0;
            dwell_n  = '0;
          end else begin
            run_n   = run_inc;
            dwell_n = dwell_inc;
          end
        end
        LOCKED: begin
          if (gap_inc >= GAP_LIM) begin
            state_n = SEARCH;
            run_n   = '0;
            dwell_n = '0;
            gap_n   = '0;
          end else begin
            gap_n = gap_inc;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  assign word      = word_p1;
  assign wordValid = vld_p1;
  assign isControl = ctl_p1;
  assign locked    = (state == LOCKED);
  assign offset    = offset_q;

`ifdef TMDS_RX_LOSS_COUNT_EN
  logic lost;
  assign lost = (state == LOCKED) && (state_n == SEARCH);

  always_ff @(posedge clock) begin
    if (reset) begin
      lossCount <= '0;
    end else if (lost && (lossCount != 8'hFF)) begin
      lossCount <= lossCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_rx_word_aligner.sv
// Randomised bench for tmds_rx_word_aligner against a bit-stream reference model.
module tb_tmds_rx_word_aligner;
  localparam int LOCK_RUN     = 8;
  localparam int SEARCH_DWELL = 64;
  localparam int LOSS_TIMEOUT = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serialValid = 1'b0;
  logic [4:0] serialData = '0;
  logic       forceRelock = 1'b0;
  logic [9:0] word;
  logic       wordValid;
  logic       isControl;
  logic       locked;
  logic [3:0] offset;
`ifdef TMDS_RX_LOSS_COUNT_EN
  logic [7:0] lossCount;
`endif

  always #5 clock = ~clock;

  tmds_rx_word_aligner #(
    .LOCK_RUN(LOCK_RUN),
    .SEARCH_DWELL(SEARCH_DWELL),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .serialValid(serialValid),
    .serialData(serialData),
    .forceRelock(forceRelock),
    .word(word),
    .wordValid(wordValid),
    .isControl(isControl),
    .locked(locked),
    .offset(offset)
`ifdef TMDS_RX_LOSS_COUNT_EN
    ,
    .lossCount(lossCount)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  // Reference model: every chunk since reset is kept; a symbol is read straight from the bit stream.
  logic [4:0] chunks [0:65535];
  int   nch = 0;
  bit   m_ready = 0;
  bit   m_locked = 0;
  int   m_off = 0, m_run = 0, m_dwell = 0, m_gap = 0, m_loss = 0;
  logic [9:0] e_word = '0;
  bit   e_valid = 0, e_ctl = 0;

  function automatic logic sbit(input int k);
    logic [4:0] c;
    if (k < 0) return 1'b0;
    c = chunks[k / 5];
    return c[k % 5];
  endfunction

  always @(posedge clock) begin
    logic [9:0] w;
    if (reset) begin
      nch = 0; m_ready = 1; m_locked = 0;
      m_off = 0; m_run = 0; m_dwell = 0; m_gap = 0; m_loss = 0;
      e_word = '0; e_valid = 0; e_ctl = 0;
    end else if (m_ready) begin
      e_valid = 0;
      if (serialValid) begin
        if (nch < 65536) chunks[nch] = serialData;
        if (nch % 2 == 1) begin
          for (int b = 0; b < 10; b++) w[b] = sbit(5 * (nch - 3) + m_off + b);
          e_word = w; e_valid = 1; e_ctl = is_tok(w);
          if (!forceRelock) begin
            if (!m_locked) begin
              m_run = e_ctl ? m_run + 1 : 0;
              m_dwell = m_dwell + 1;
              if (m_run >= LOCK_RUN) begin
                m_locked = 1; m_run = 0; m_dwell = 0; m_gap = 0;
              end else if (m_dwell >= SEARCH_DWELL) begin
                m_off = (m_off + 1) % 10; m_dwell = 0; m_run = 0;
              end
            end else begin
              m_gap = e_ctl ? 0 : m_gap + 1;
              if (m_gap >= LOSS_TIMEOUT) begin
                m_locked = 0; m_run = 0; m_dwell = 0; m_gap = 0;
                if (m_loss < 255) m_loss++;
              end
            end
          end
        end
        nch++;
      end
      if (forceRelock) begin
        if (m_locked && m_loss < 255) m_loss++;
        m_locked = 0; m_off = (m_off + 1) % 10;
        m_run = 0; m_dwell = 0; m_gap = 0;
      end
    end
  end

  bit prev_wv = 0;
  always @(negedge clock) begin
    if (m_ready) begin
      chk("wordValid", 32'(wordValid), 32'(e_valid));
      chk("word", 32'(word), 32'(e_word));
      chk("isControl", 32'(isControl), 32'(e_ctl));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("offset", 32'(offset), 32'(m_off));
`ifdef TMDS_RX_LOSS_COUNT_EN
      chk("lossCount", 32'(lossCount), 32'(m_loss));
`endif
      chk("wv_back_to_back", 32'(wordValid & prev_wv), 32'd0);
      prev_wv = wordValid;
    end
  end

  // Stimulus: a bit queue drained five bits per valid cycle.
  logic bitq[$];

  task automatic push_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'b0);
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom); while (is_tok(w));
    return w;
  endfunction

  function automatic logic [9:0] rand_tok();
    case ($urandom_range(3))
      0: return 10'h354;
      1: return 10'h0AB;
      2: return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic drive(input bit v, input bit f, input bit r);
    logic [4:0] c;
    @(negedge clock);
    reset = r; forceRelock = f; serialValid = v;
    if (v) begin
      for (int i = 0; i < 5; i++) c[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      serialData = c;
    end else begin
      serialData = 5'($urandom);
    end
  endtask

  task automatic flush(input int stall_pct, input int force_pct);
    int r;
    while (bitq.size() >= 5) begin
      r = $urandom_range(99);
      if (r < force_pct) drive(0, 1, 0);
      else if (r < stall_pct) drive(0, 0, 0);
      else drive(1, 0, 0);
    end
  endtask

  task automatic do_reset();
    bitq.delete();
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
  endtask

  initial begin
    // 1: aligned 0x354 stream
    do_reset();
    chk("reset_word", 32'(word), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    for (int i = 0; i < 20; i++) push_word(10'h354);
    flush(0, 0);
    drive(0, 0, 0);
    chk("t1_locked", 32'(locked), 32'h1);
    chk("t1_offset", 32'(offset), 32'h0);
    chk("t1_word", 32'(word), 32'h354);
    chk("t1_isControl", 32'(isControl), 32'h1);

    // 2: stream delayed 3 bits, search steps up to offset 3
    do_reset();
    push_zeros(3);
    for (int i = 0; i < 230; i++) push_word(10'h354);
    flush(0, 0);
    drive(0, 0, 0);
    chk("t2_locked", 32'(locked), 32'h1);
    chk("t2_offset", 32'(offset), 32'h3);

    // 3: loss timeout on non-control words, then relock at the same offset
    for (int i = 0; i < 205; i++) push_word(rand_data());
    flush(20, 0);
    drive(0, 0, 0);
    chk("t3_unlocked", 32'(locked), 32'h0);
    chk("t3_offset_kept", 32'(offset), 32'h3);
    for (int i = 0; i < 20; i++) push_word(rand_tok());
    flush(20, 0);
    drive(0, 0, 0);
    chk("t3_relocked", 32'(locked), 32'h1);

    // 4: strictly alternating serialValid
    do_reset();
    for (int i = 0; i < 30; i++) push_word(rand_tok());
    while (bitq.size() >= 5) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    chk("t4_locked", 32'(locked), 32'h1);
    chk("t4_offset", 32'(offset), 32'h0);

    // 5: lock at offset 9, then forceRelock wraps to 0
    do_reset();
    push_zeros(9);
    for (int i = 0; i < 9 * SEARCH_DWELL + 40; i++) push_word(10'h354);
    flush(0, 0);
    drive(0, 0, 0);
    chk("t5_locked", 32'(locked), 32'h1);
    chk("t5_offset9", 32'(offset), 32'h9);
    drive(0, 1, 0);
    drive(0, 0, 0);
    chk("t5_force_unlocked", 32'(locked), 32'h0);
    chk("t5_force_offset", 32'(offset), 32'h0);
`ifdef TMDS_RX_LOSS_COUNT_EN
    chk("t5_lossCount", 32'(lossCount), 32'h1);
`endif

    // 6: reset mid-word while locked, then 7 tokens + data never lock
    do_reset();
    for (int i = 0; i < 20; i++) push_word(10'h354);
    flush(0, 0);
    push_word(10'h354);
    drive(1, 0, 0);
    chk("t6_pre_locked", 32'(locked), 32'h1);
    bitq.delete();
    drive(0, 0, 1);
    drive(0, 0, 0);
    chk("t6_word0", 32'(word), 32'h0);
    chk("t6_wv0", 32'(wordValid), 32'h0);
    chk("t6_ctl0", 32'(isControl), 32'h0);
    chk("t6_locked0", 32'(locked), 32'h0);
    chk("t6_offset0", 32'(offset), 32'h0);
    for (int i = 0; i < 7; i++) push_word(10'h354);
    for (int i = 0; i < 10; i++) push_word(rand_data());
    flush(0, 0);
    drive(0, 0, 0);
    chk("t6_never_locked", 32'(locked), 32'h0);

    // random traffic: token/data bursts, stalls and occasional forced relocks
    do_reset();
    push_zeros($urandom_range(9));
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i < $urandom_range(12, 1); i++) push_word(rand_tok());
      end else begin
        for (int i = 0; i < (($urandom_range(3) == 0) ? $urandom_range(260, 1) : $urandom_range(20, 1)); i++)
          push_word(rand_data());
      end
      flush(30, 1);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
